// File: rtl/xbar_pkg.sv
// xbar_pkg: shared types, default widths and slave decode for xbar_nxm.
// Ports: none (package).
package xbar_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_N_MASTERS  = 4;
  localparam int DEF_N_SLAVES   = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int MAX_ADDR_WIDTH = 64;

  // Slave index taken from the top sel_w bits of an addr_w-bit address.
  function automatic logic [31:0] slave_sel(
    input logic [MAX_ADDR_WIDTH-1:0] addr,
    input int                        addr_w,
    input int                        sel_w
  );
    logic [31:0] mask;
    mask = (32'd1 << sel_w) - 32'd1;
    return 32'(addr >> (addr_w - sel_w)) & mask;
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// xbar_rr_arbiter: per-slave locking round-robin arbiter (IDLE/BUSY).
// Ports: clk, rst, req[N], ack -> grant[N] (one-hot, registered), busy.
module xbar_rr_arbiter
  import xbar_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 ack,
  output logic [N_MASTERS-1:0] grant,
  output logic                 busy
);

  localparam int PW = $clog2(N_MASTERS);

  arb_state_t           state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        gidx;
  logic [PW-1:0]        pick;
  logic [PW-1:0]        idx;
  logic [PW-1:0]        ptr_nxt;
  logic [N_MASTERS-1:0] pick_oh;
  logic                 found;

  // First requester at or after ptr, wrapping past the top index.
  always_comb begin
    pick    = '0;
    idx     = '0;
    found   = 1'b0;
    pick_oh = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = PW'((32'(ptr) + 32'(k)) % N_MASTERS);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    pick_oh[pick] = found;
  end

  assign ptr_nxt = (gidx == PW'(N_MASTERS - 1)) ? '0 : gidx + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      grant <= '0;
      ptr   <= '0;
      gidx  <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (found) begin
            state <= ARB_BUSY;
            gidx  <= pick;
            grant <= pick_oh;
          end
        end
        ARB_BUSY: begin
          if (ack) begin
            state <= ARB_IDLE;
            grant <= '0;
            ptr   <= ptr_nxt;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign busy = (state == ARB_BUSY);

endmodule

// File: rtl/xbar_nxm.sv
// xbar_nxm: N-master x M-slave req/ack crossbar, one RR arbiter per slave.
// Ports: m_req/m_addr/m_we/m_wdata -> s_*; s_ack/s_rdata -> m_ack/m_rdata;
//   dbg_grant = per-slave one-hot grants. XBAR_RESP_REG_EN registers m_ack/m_rdata.
module xbar_nxm
  import xbar_pkg::*;
#(
  parameter int N_MASTERS  = DEF_N_MASTERS,
  parameter int N_SLAVES   = DEF_N_SLAVES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTERS-1:0]           m_req,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [N_MASTERS-1:0]           m_we,
  input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [N_MASTERS-1:0]           m_ack,
  output logic [N_MASTERS*DATA_WIDTH-1:0] m_rdata,
  output logic [N_SLAVES-1:0]            s_req,
  output logic [N_SLAVES*ADDR_WIDTH-1:0] s_addr,
  output logic [N_SLAVES-1:0]            s_we,
  output logic [N_SLAVES*DATA_WIDTH-1:0] s_wdata,
  input  logic [N_SLAVES-1:0]            s_ack,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata,
  output logic [N_SLAVES*N_MASTERS-1:0]  dbg_grant
);

  localparam int SEL_W = $clog2(N_SLAVES);
  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;

  logic [N_MASTERS-1:0]                avail;
  logic [N_SLAVES-1:0][N_MASTERS-1:0]  tgt;
  logic [N_SLAVES-1:0][N_MASTERS-1:0]  gnt;
  logic [N_SLAVES-1:0]                 busy;
  logic [N_MASTERS-1:0]                ack_c;
  logic [N_MASTERS*DW-1:0]             rdata_c;

  always_comb begin
    tgt = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      for (int j = 0; j < N_SLAVES; j++) begin
        if (avail[i] &&
            slave_sel(MAX_ADDR_WIDTH'(m_addr[i*AW +: AW]), AW, SEL_W)
              == 32'(j)) begin
          tgt[j][i] = 1'b1;
        end
      end
    end
  end

  for (genvar j = 0; j < N_SLAVES; j++) begin : g_arb
    xbar_rr_arbiter #(
      .N_MASTERS(N_MASTERS)
    ) u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (tgt[j]),
      .ack  (s_ack[j]),
      .grant(gnt[j]),
      .busy (busy[j])
    );
  end

  assign s_req     = busy;
  assign dbg_grant = gnt;

  always_comb begin
    s_addr  = '0;
    s_we    = '0;
    s_wdata = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (gnt[j][i]) begin
          s_addr[j*AW +: AW]  = s_addr[j*AW +: AW] | m_addr[i*AW +: AW];
          s_we[j]             = s_we[j] | m_we[i];
          s_wdata[j*DW +: DW] = s_wdata[j*DW +: DW] | m_wdata[i*DW +: DW];
        end
      end
    end
  end

  // Grants are one-hot and only held while BUSY, so an OR-mux suffices.
  always_comb begin
    ack_c   = '0;
    rdata_c = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (gnt[j][i] && s_ack[j]) begin
          ack_c[i]             = 1'b1;
          rdata_c[i*DW +: DW]  = rdata_c[i*DW +: DW] | s_rdata[j*DW +: DW];
        end
      end
    end
  end

`ifdef XBAR_RESP_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack   <= '0;
      m_rdata <= '0;
    end else begin
      m_ack   <= ack_c;
      m_rdata <= rdata_c;
    end
  end

  // The slave freed a cycle before the master saw its ack; the master's
  // still-high req must not win a fresh grant in that gap.
  assign avail = m_req & ~m_ack;
`else
  assign m_ack   = ack_c;
  assign m_rdata = rdata_c;
  assign avail   = m_req;
`endif

`ifndef SYNTHESIS
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_m_chk
    a_m_hold: assert property (
      @(posedge clk) disable iff (rst)
      m_req[i] && !m_ack[i] |=>
        m_ack[i] || (m_req[i] && $stable(m_addr[i*AW +: AW])))
      else $error("xbar_nxm: master %0d dropped req or changed addr", i);
  end

  for (genvar j = 0; j < N_SLAVES; j++) begin : g_s_chk
    a_s_ack: assert property (
      @(posedge clk) disable iff (rst)
      s_ack[j] |-> s_req[j])
      else $error("xbar_nxm: s_ack on idle slave %0d", j);
  end
`endif

endmodule

// File: tb/tb_xbar_nxm.sv
// tb_xbar_nxm: directed self-checking bench for xbar_nxm.
// Covers reset, single, parallel, contention, wrap-around and a 3x8 64-bit build.
module tb_xbar_nxm;

  localparam int NM = 4;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef XBAR_RESP_REG_EN
  localparam int RL = 1;
`else
  localparam int RL = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_req, m_we, m_ack;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata, m_rdata;
  logic [NS-1:0]    s_req, s_we, s_ack;
  logic [NS*AW-1:0] s_addr;
  logic [NS*DW-1:0] s_wdata, s_rdata;
  logic [NS*NM-1:0] dbg_grant;

  logic [2:0]   c_m_req, c_m_we, c_m_ack;
  logic [95:0]  c_m_addr;
  logic [191:0] c_m_wdata, c_m_rdata;
  logic [7:0]   c_s_req, c_s_we, c_s_ack;
  logic [255:0] c_s_addr;
  logic [511:0] c_s_wdata, c_s_rdata;
  logic [23:0]  c_dbg;

  int total = 0;
  int bad   = 0;

  xbar_nxm u_dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .dbg_grant(dbg_grant)
  );

  xbar_nxm #(
    .N_MASTERS(3), .N_SLAVES(8), .ADDR_WIDTH(32), .DATA_WIDTH(64)
  ) u_cfg (
    .clk(clk), .rst(rst),
    .m_req(c_m_req), .m_addr(c_m_addr), .m_we(c_m_we), .m_wdata(c_m_wdata),
    .m_ack(c_m_ack), .m_rdata(c_m_rdata),
    .s_req(c_s_req), .s_addr(c_s_addr), .s_we(c_s_we), .s_wdata(c_s_wdata),
    .s_ack(c_s_ack), .s_rdata(c_s_rdata), .dbg_grant(c_dbg)
  );

  // Drives one slave-ack cycle and captures the master side in that
  // cycle (a0/r0) and the next (a1/r1); drop masters release req after.
  task automatic do_ack(
    input  logic [NS-1:0]    sack,
    input  logic [NS*DW-1:0] sdata,
    input  logic [NM-1:0]    drop,
    output logic [NM-1:0]    a0,
    output logic [NM-1:0]    a1,
    output logic [NM*DW-1:0] r0,
    output logic [NM*DW-1:0] r1
  );
    s_ack   = sack;
    s_rdata = sdata;
    #1;
    a0 = m_ack;
    r0 = m_rdata;
    @(negedge clk);
    s_ack   = '0;
    s_rdata = '0;
    m_req   = m_req & ~drop;
    #1;
    a1 = m_ack;
    r1 = m_rdata;
  endtask

  task automatic test_reset();
    logic [NM-1:0]    a0, a1;
    logic [NM*DW-1:0] r0, r1;
    rst = 1'b1;
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    s_ack = '0; s_rdata = '0;
    c_m_req = '0; c_m_we = '0; c_m_addr = '0; c_m_wdata = '0;
    c_s_ack = '0; c_s_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (s_req !== 4'h0 || m_ack !== 4'h0 || dbg_grant !== 16'h0) begin
      bad++;
      $display("FAIL reset_ctl s_req=%h m_ack=%h grant=%h want 0",
               s_req, m_ack, dbg_grant);
    end
    total++;
    if (s_addr !== '0 || s_we !== '0 || s_wdata !== '0 || m_rdata !== '0) begin
      bad++;
      $display("FAIL reset_data s_addr=%h s_wdata=%h m_rdata=%h want 0",
               s_addr, s_wdata, m_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    m_addr[2*AW +: AW] = 32'h4000_0000;
    m_req[2] = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (dbg_grant[1*NM +: NM] !== 4'b0100) begin
      bad++;
      $display("FAIL reset_pre_grant got=%b want=0100", dbg_grant[1*NM +: NM]);
    end
    do_ack(4'b0010, {64'h0, 32'h1234_5678, 32'h0}, 4'b0100, a0, a1, r0, r1);
    total++;
    if ((RL != 0 ? a1 : a0) !== 4'b0100) begin
      bad++;
      $display("FAIL reset_pre_ack got=%b want=0100", RL != 0 ? a1 : a0);
    end
    @(negedge clk);
    m_req[2] = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (s_req !== 4'b0010) begin
      bad++;
      $display("FAIL reset_inflight s_req=%b want=0010", s_req);
    end
    @(negedge clk);
    rst   = 1'b1;
    m_req = '0;
    #1;
    total++;
    if (s_req !== 4'h0 || m_ack !== 4'h0 || dbg_grant !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid s_req=%h m_ack=%h grant=%h want 0",
               s_req, m_ack, dbg_grant);
    end
    @(negedge clk);
    rst = 1'b0;
    m_addr[0*AW +: AW] = 32'h4000_0000;
    m_addr[3*AW +: AW] = 32'h4000_000C;
    m_req = 4'b1001;
    @(negedge clk);
    #1;
    total++;
    if (dbg_grant !== 16'h0010 || s_addr[1*AW +: AW] !== 32'h4000_0000) begin
      bad++;
      $display("FAIL reset_ptr0 grant=%h addr=%h want 0010/40000000",
               dbg_grant, s_addr[1*AW +: AW]);
    end
    do_ack(4'b0010, {64'h0, 32'hAAAA_0000, 32'h0}, 4'b0001, a0, a1, r0, r1);
    total++;
    if ((RL != 0 ? a1 : a0) !== 4'b0001) begin
      bad++;
      $display("FAIL reset_ack_m0 got=%b want=0001", RL != 0 ? a1 : a0);
    end
    @(negedge clk);
    #1;
    total++;
    if (dbg_grant !== 16'h0080) begin
      bad++;
      $display("FAIL reset_next_m3 grant=%h want=0080", dbg_grant);
    end
    do_ack(4'b0010, {64'h0, 32'hAAAA_0003, 32'h0}, 4'b1000, a0, a1, r0, r1);
    total++;
    if ((RL != 0 ? a1 : a0) !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ack_m3 got=%b want=1000", RL != 0 ? a1 : a0);
    end
  endtask

  task automatic test_single();
    logic [NM-1:0]    a0, a1;
    logic [NM*DW-1:0] r0, r1;
    @(negedge clk);
    m_addr[2*AW +: AW] = 32'hC000_0010;
    m_we[2]  = 1'b0;
    m_req[2] = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (s_req !== 4'b1000 || s_addr[3*AW +: AW] !== 32'hC000_0010 ||
        s_we !== 4'b0000) begin
      bad++;
      $display("FAIL single_route s_req=%b addr=%h we=%b want 1000/c0000010/0",
               s_req, s_addr[3*AW +: AW], s_we);
    end
    @(negedge clk);
    #1;
    total++;
    if (s_req !== 4'b1000 || m_ack !== 4'h0 || m_rdata !== '0) begin
      bad++;
      $display("FAIL single_wait s_req=%b m_ack=%b m_rdata=%h want 1000/0/0",
               s_req, m_ack, m_rdata);
    end
    @(negedge clk);
    do_ack(4'b1000, {32'hDEAD_BEEF, 96'h0}, 4'b0100, a0, a1, r0, r1);
    total++;
    if ((RL != 0 ? a1 : a0) !== 4'b0100 ||
        (RL != 0 ? r1 : r0) !== {32'h0, 32'hDEAD_BEEF, 64'h0}) begin
      bad++;
      $display("FAIL single_ack m_ack=%b m_rdata=%h want 0100/deadbeef@m2",
               RL != 0 ? a1 : a0, RL != 0 ? r1 : r0);
    end
    total++;
    if ((RL != 0 ? a0 : a1) !== 4'h0 || (RL != 0 ? r0 : r1) !== '0) begin
      bad++;
      $display("FAIL single_ack_once m_ack=%b m_rdata=%h want 0/0",
               RL != 0 ? a0 : a1, RL != 0 ? r0 : r1);
    end
    @(negedge clk);
    #1;
    total++;
    if (s_req !== 4'h0) begin
      bad++;
      $display("FAIL single_release s_req=%b want=0", s_req);
    end
  endtask

  task automatic test_parallel();
    logic [NM-1:0]    a0, a1;
    logic [NM*DW-1:0] r0, r1;
    @(negedge clk);
    m_addr  = {32'h0000_002C, 32'hC000_0028, 32'h8000_0024, 32'h4000_0020};
    m_wdata = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
    m_we    = 4'b1111;
    m_req   = 4'b1111;
    @(negedge clk);
    #1;
    total++;
    if (s_req !== 4'b1111 || s_we !== 4'b1111 || dbg_grant !== 16'h4218) begin
      bad++;
      $display("FAIL par_grant s_req=%b we=%b grant=%h want 1111/1111/4218",
               s_req, s_we, dbg_grant);
    end
    total++;
    if (s_addr !== {32'hC000_0028, 32'h8000_0024, 32'h4000_0020, 32'h0000_002C}) begin
      bad++;
      $display("FAIL par_addr got=%h", s_addr);
    end
    total++;
    if (s_wdata !== {32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000, 32'hA0A0_0003}) begin
      bad++;
      $display("FAIL par_wdata got=%h", s_wdata);
    end
    do_ack(4'b1111,
           {32'h5150_0003, 32'h5150_0002, 32'h5150_0001, 32'h5150_0000},
           4'b1111, a0, a1, r0, r1);
    total++;
    if ((RL != 0 ? a1 : a0) !== 4'b1111 ||
        (RL != 0 ? r1 : r0) !==
          {32'h5150_0000, 32'h5150_0003, 32'h5150_0002, 32'h5150_0001}) begin
      bad++;
      $display("FAIL par_resp m_ack=%b m_rdata=%h",
               RL != 0 ? a1 : a0, RL != 0 ? r1 : r0);
    end
    m_we = '0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [NM-1:0]    a0, a1, seen, e;
    logic [NM*DW-1:0] r0, r1, rr;
    int cnt [NM];
    int x;
    bool_wait: begin end
    for (int i = 0; i < NM; i++) begin
      cnt[i] = 0;
      m_addr[i*AW +: AW] = 32'h0000_0100 + 32'(4 * i);
    end
    m_req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      x = n % NM;
      e = '0;
      e[x] = 1'b1;
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        #1;
        if (s_req[0]) break;
      end
      total++;
      if (s_req[0] !== 1'b1) begin
        bad++;
        $display("FAIL cont_timeout n=%0d s_req=%b want s_req[0]=1", n, s_req);
        m_req = '0;
        return;
      end
      total++;
      if (dbg_grant[NM-1:0] !== e || s_addr[AW-1:0] !== 32'h100 + 32'(4 * x)) begin
        bad++;
        $display("FAIL cont_grant n=%0d grant=%b addr=%h want %b/%h",
                 n, dbg_grant[NM-1:0], s_addr[AW-1:0], e, 32'h100 + 32'(4 * x));
      end
      do_ack(4'b0001, {96'h0, 32'hC0DE_0000 + 32'(n)},
             (n >= 4) ? e : 4'b0000, a0, a1, r0, r1);
      seen = (RL != 0) ? a1 : a0;
      rr   = (RL != 0) ? r1 : r0;
      for (int i = 0; i < NM; i++) cnt[i] += int'(seen[i]);
      total++;
      if (seen !== e || rr[x*DW +: DW] !== 32'hC0DE_0000 + 32'(n)) begin
        bad++;
        $display("FAIL cont_ack n=%0d m_ack=%b rdata=%h want %b/%h",
                 n, seen, rr[x*DW +: DW], e, 32'hC0DE_0000 + 32'(n));
      end
    end
    for (int i = 0; i < NM; i++) begin
      total++;
      if (cnt[i] !== 2) begin
        bad++;
        $display("FAIL cont_count m%0d acks=%0d want=2", i, cnt[i]);
      end
    end
    m_req = '0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [NM-1:0]    a0, a1, seen, e;
    logic [NM*DW-1:0] r0, r1;
    int order [7] = '{2, 3, 1, 2, 3, 0, 1};
    for (int i = 0; i < NM; i++) m_addr[i*AW +: AW] = 32'h8000_0200 + 32'(4 * i);
    for (int n = 0; n < 7; n++) begin
      if (n == 0) m_req = 4'b0100;
      if (n == 1) m_req = 4'b1010;
      if (n == 3) m_req = 4'b1111;
      e = '0;
      e[order[n]] = 1'b1;
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        #1;
        if (s_req[2]) break;
      end
      total++;
      if (s_req[2] !== 1'b1) begin
        bad++;
        $display("FAIL wrap_timeout n=%0d s_req=%b want s_req[2]=1", n, s_req);
        m_req = '0;
        return;
      end
      total++;
      if (dbg_grant[2*NM +: NM] !== e) begin
        bad++;
        $display("FAIL wrap_grant n=%0d grant=%b want=%b",
                 n, dbg_grant[2*NM +: NM], e);
      end
      do_ack(4'b0100, {32'h0, 32'h7777_0000 + 32'(n), 64'h0}, e,
             a0, a1, r0, r1);
      seen = (RL != 0) ? a1 : a0;
      total++;
      if (seen !== e) begin
        bad++;
        $display("FAIL wrap_ack n=%0d m_ack=%b want=%b", n, seen, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_config();
    logic [2:0]   a0, a1;
    logic [191:0] r0, r1, rr;
    @(negedge clk);
    c_m_addr[1*32 +: 32]  = 32'hA000_0040;
    c_m_wdata[1*64 +: 64] = 64'h0123_4567_89AB_CDEF;
    c_m_we  = 3'b010;
    c_m_req = 3'b010;
    @(negedge clk);
    #1;
    total++;
    if (c_s_req !== 8'b0010_0000 || c_s_we !== 8'b0010_0000 ||
        c_dbg[5*3 +: 3] !== 3'b010) begin
      bad++;
      $display("FAIL cfg_route s_req=%b we=%b grant=%b want 00100000/00100000/010",
               c_s_req, c_s_we, c_dbg[5*3 +: 3]);
    end
    total++;
    if (c_s_wdata[5*64 +: 64] !== 64'h0123_4567_89AB_CDEF ||
        c_s_addr[5*32 +: 32] !== 32'hA000_0040) begin
      bad++;
      $display("FAIL cfg_data wdata=%h addr=%h want 0123456789abcdef/a0000040",
               c_s_wdata[5*64 +: 64], c_s_addr[5*32 +: 32]);
    end
    c_s_ack = 8'b0010_0000;
    c_s_rdata[5*64 +: 64] = 64'hFEDC_BA98_7654_3210;
    #1;
    a0 = c_m_ack;
    r0 = c_m_rdata;
    @(negedge clk);
    c_s_ack   = '0;
    c_s_rdata = '0;
    c_m_req   = '0;
    #1;
    a1 = c_m_ack;
    r1 = c_m_rdata;
    rr = (RL != 0) ? r1 : r0;
    total++;
    if ((RL != 0 ? a1 : a0) !== 3'b010 || rr[1*64 +: 64] !== 64'hFEDC_BA98_7654_3210) begin
      bad++;
      $display("FAIL cfg_ack m_ack=%b rdata=%h want 010/fedcba9876543210",
               RL != 0 ? a1 : a0, rr[1*64 +: 64]);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_parallel();
    test_contention();
    test_wrap();
    test_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
